// File: rtl/wishbone_block_reader.sv
// wishbone_block_reader
// Wishbone Classic Pipelined block-read initiator. A Start with a non-zero
// Length issues Length consecutive word reads from BaseAddr. Responses land
// in a small FIFO that drains over a valid/ready stream as {parity, data}.
// Requests are only issued while a FIFO slot is guaranteed for each one, so
// ACKs never need to be back-pressured.
module wishbone_block_reader #(
  parameter int AddressWidth = 12,
  parameter int DataWidth    = 8,
  parameter int Parity       = 1,
  parameter int FifoDepth    = 4,
  parameter int LengthWidth  = 12
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Start,
  input  logic [AddressWidth-1:0]  BaseAddr,
  input  logic [LengthWidth-1:0]   Length,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Error,
  output logic                     CYC,
  output logic                     STB,
  output logic                     WE,
  output logic [AddressWidth-1:0]  ADDR,
  output logic [DataWidth/8-1:0]   SEL,
  input  logic                     STALL,
  input  logic                     ACK,
  input  logic                     ERR,
  input  logic [DataWidth-1:0]     DAT_ToInitiator,
  input  logic [DataWidth/8-1:0]   TGD_ToInitiator,
  output logic [DataWidth-1:0]     OutData,
  output logic [DataWidth/8-1:0]   OutParity,
  output logic                     OutValid,
  input  logic                     OutReady
);

  localparam int SelWidth   = DataWidth / 8;
  localparam int PtrWidth   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CountWidth = $clog2(FifoDepth) + 1;
  localparam int SumWidth   = CountWidth + 1;
  localparam int EntryWidth = SelWidth + DataWidth;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                   state_reg;
  logic                     cyc_reg;
  logic                     stb_reg;
  logic [AddressWidth-1:0]  addr_reg;
  logic [SelWidth-1:0]      sel_reg;
  logic                     busy_reg;
  logic                     done_reg;
  logic                     error_reg;

  // Requests still to be issued, requests awaiting a response, FIFO fill.
  logic [LengthWidth-1:0]   remaining_reg;
  logic [CountWidth-1:0]    outstanding_reg;
  logic [CountWidth-1:0]    outstanding_next;
  logic [CountWidth-1:0]    count_reg;
  logic [CountWidth-1:0]    count_next;
  logic [PtrWidth-1:0]      wr_ptr_reg;
  logic [PtrWidth-1:0]      rd_ptr_reg;

  logic [EntryWidth-1:0]    fifo_mem [FifoDepth];
  logic [SelWidth-1:0]      parity_in;

  logic                     accept;
  logic                     push;
  logic                     pop;
  logic                     err_hit;
  logic                     credit_ok;

  // Per-byte parity capture; with parity disabled the tag bits are forced low.
  genvar gi;
  generate
    for (gi = 0; gi < SelWidth; gi++) begin : g_parity
      if (Parity != 0) begin : g_on
        assign parity_in[gi] = TGD_ToInitiator[gi];
      end else begin : g_off
        assign parity_in[gi] = 1'b0;
      end
    end
  endgenerate

  // Bus events of this cycle and the credit check for next cycle's strobe.
  always_comb begin
    accept  = stb_reg && !STALL;
    err_hit = cyc_reg && ERR && ((state_reg == ISSUE) || (state_reg == WAIT));
    // A stray ACK with nothing outstanding is dropped; an ACK alongside ERR is too.
    push    = cyc_reg && ACK && !ERR && (outstanding_reg != '0);
    pop     = (count_reg != '0) && OutReady;

    outstanding_next = outstanding_reg;
    if (accept && !push) begin
      outstanding_next = outstanding_reg + CountWidth'(1);
    end else if (!accept && push) begin
      outstanding_next = outstanding_reg - CountWidth'(1);
    end

    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CountWidth'(1);
    end else if (!push && pop) begin
      count_next = count_reg - CountWidth'(1);
    end

    // Every request in flight owns a FIFO slot, so strobe only while one is free.
    credit_ok = ({1'b0, outstanding_next} + {1'b0, count_next}) < SumWidth'(FifoDepth);
  end

  // Response FIFO storage; flushes only move the pointers, contents need no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {parity_in, DAT_ToInitiator};
    end
  end

  // Transfer sequencing, bus outputs, counters and FIFO pointers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg       <= IDLE;
      cyc_reg         <= 1'b0;
      stb_reg         <= 1'b0;
      addr_reg        <= '0;
      sel_reg         <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      error_reg       <= 1'b0;
      remaining_reg   <= '0;
      outstanding_reg <= '0;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      done_reg        <= 1'b0;
      outstanding_reg <= outstanding_next;
      count_reg       <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PtrWidth'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PtrWidth'(1);
      end

      case (state_reg)
        IDLE: begin
          if (Start) begin
            if (Length != '0) begin
              // The FIFO is empty and nothing is outstanding here, so the
              // first strobe always has credit.
              state_reg     <= ISSUE;
              addr_reg      <= BaseAddr;
              remaining_reg <= Length;
              error_reg     <= 1'b0;
              cyc_reg       <= 1'b1;
              stb_reg       <= 1'b1;
              sel_reg       <= '1;
              busy_reg      <= 1'b1;
            end else begin
              done_reg <= 1'b1;
            end
          end
        end

        ISSUE: begin
          if (err_hit) begin
            state_reg       <= IDLE;
            cyc_reg         <= 1'b0;
            stb_reg         <= 1'b0;
            sel_reg         <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b1;
            error_reg       <= 1'b1;
            outstanding_reg <= '0;
            count_reg       <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
          end else begin
            if (accept) begin
              addr_reg      <= addr_reg + AddressWidth'(1);
              remaining_reg <= remaining_reg - LengthWidth'(1);
            end
            if (accept && (remaining_reg == LengthWidth'(1))) begin
              state_reg <= WAIT;
              stb_reg   <= 1'b0;
              sel_reg   <= '0;
            end else begin
              stb_reg <= credit_ok;
              sel_reg <= credit_ok ? '1 : '0;
            end
          end
        end

        WAIT: begin
          if (err_hit) begin
            state_reg       <= IDLE;
            cyc_reg         <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b1;
            error_reg       <= 1'b1;
            outstanding_reg <= '0;
            count_reg       <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
          end else if (outstanding_next == '0) begin
            state_reg <= DRAIN;
            cyc_reg   <= 1'b0;
          end
        end

        DRAIN: begin
          // The bus is released; finish once the consumer has taken every word.
          if (count_reg == '0) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          cyc_reg   <= 1'b0;
          stb_reg   <= 1'b0;
          sel_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign CYC   = cyc_reg;
  assign STB   = stb_reg;
  assign WE    = 1'b0;
  assign ADDR  = addr_reg;
  assign SEL   = sel_reg;
  assign Busy  = busy_reg;
  assign Done  = done_reg;
  assign Error = error_reg;

  // The stream presents the FIFO head directly; it only moves on a pop.
  assign {OutParity, OutData} = fifo_mem[rd_ptr_reg];
  assign OutValid             = (count_reg != '0);

endmodule

// File: tb/tb_wishbone_block_reader.sv
// Bench for wishbone_block_reader: a randomized pipelined target and consumer
// drive the block, and a queue-based model of the transfer (addresses to
// expect, words in flight, words buffered, words delivered) is checked
// against the outputs on every cycle, plus directed literal checks.
module tb_wishbone_block_reader;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = 12;
  localparam int AMOD  = 4096;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          Start;
  logic [AW-1:0] BaseAddr;
  logic [LW-1:0] Length;
  logic          Busy, Done, Error, CYC, STB, WE;
  logic [AW-1:0] ADDR;
  logic [0:0]    SEL;
  logic          STALL, ACK, ERR;
  logic [DW-1:0] DAT;
  logic [0:0]    TGD;
  logic [DW-1:0] OutData;
  logic [0:0]    OutParity;
  logic          OutValid, OutReady;

  always #5 clk = ~clk;

  wishbone_block_reader #(
    .AddressWidth(AW), .DataWidth(DW), .Parity(1), .FifoDepth(DEPTH), .LengthWidth(LW)
  ) dut (
    .CLK(clk), .RST(rst_n), .Start(Start), .BaseAddr(BaseAddr), .Length(Length),
    .Busy(Busy), .Done(Done), .Error(Error), .CYC(CYC), .STB(STB), .WE(WE),
    .ADDR(ADDR), .SEL(SEL), .STALL(STALL), .ACK(ACK), .ERR(ERR),
    .DAT_ToInitiator(DAT), .TGD_ToInitiator(TGD), .OutData(OutData),
    .OutParity(OutParity), .OutValid(OutValid), .OutReady(OutReady)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  // Target memory contents
  logic [7:0] mem_data [AMOD];
  logic [0:0] mem_tgd  [AMOD];

  // Transfer model
  bit  m_busy, m_error, m_err_pending, m_zero_pending;
  int  m_base, m_len, m_issued, m_popped, m_out, resp_idx, err_at;
  logic [8:0] q_fifo[$];
  int  tq_addr[$];
  int  tq_cyc[$];

  // Stimulus knobs
  int  stall_pct, ack_pct, ready_pct, stray_pct, stall2_left;
  bit  start_req, rst_req, rst_check;
  int  start_base, start_len;

  // Per-transfer observations
  int  acc_addr[$];
  int  acc_cyc[$];
  int  first_stb, first_valid, start_cyc, done_cyc, done_count, t3_count;
  bit  cyc_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // One clock cycle: check outputs, choose this cycle's inputs, advance the model.
  task automatic step();
    logic [8:0] w;
    int ea;
    int a;
    @(negedge clk);
    cycle++;

    if (rst_check) begin
      chk("rst_cyc", CYC, 0);
      chk("rst_stb", STB, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_error", Error, 0);
      chk("rst_valid", OutValid, 0);
      chk("rst_addr", ADDR, 0);
      chk("rst_sel", SEL, 0);
      rst_check = 0;
    end

    chk("we", WE, 0);
    chk("sel", SEL, STB ? 1 : 0);
    if (CYC) cyc_seen = 1;
    if (STB && first_stb < 0) first_stb = cycle;
    if (OutValid && first_valid < 0) first_valid = cycle;
    if (STB && ADDR == 12'h041) t3_count++;
    if (STB) begin
      chk("stb_cyc", CYC, 1);
      chk("stb_credit", (m_out + q_fifo.size()) < DEPTH, 1);
      chk("stb_addr", ADDR, (m_base + m_issued) % AMOD);
      chk("stb_in_transfer", m_busy, 1);
    end
    chk("out_valid", OutValid, q_fifo.size() != 0);
    if (OutValid && q_fifo.size() != 0) chk("out_word", {OutParity, OutData}, q_fifo[0]);
    chk("error", Error, m_error);
    if (!m_busy && !m_err_pending) chk("idle_cyc", CYC, 0);

    if (m_zero_pending) begin
      chk("zero_done", Done, 1);
      chk("zero_cyc", CYC, 0);
      m_zero_pending = 0;
      done_count++;
      done_cyc = cycle;
    end else if (m_err_pending) begin
      chk("err_done", Done, 1);
      chk("err_cyc", CYC, 0);
      chk("err_stb", STB, 0);
      chk("err_busy", Busy, 0);
      m_err_pending = 0;
      m_busy = 0;
      done_count++;
      done_cyc = cycle;
    end else if (Done) begin
      chk("done_expected", m_busy && (m_popped == m_len) && (q_fifo.size() == 0), 1);
      chk("done_busy", Busy, 0);
      m_busy = 0;
      done_count++;
      done_cyc = cycle;
    end else if (m_busy) begin
      chk("busy", Busy, 1);
    end else begin
      chk("idle_busy", Busy, 0);
    end

    // Inputs for this cycle
    Start = 0;
    ACK = 0;
    ERR = 0;
    STALL = 0;
    DAT = 8'($urandom);
    TGD = 1'($urandom);
    if (rst_req) begin
      rst_n = 0;
      OutReady = 0;
      rst_req = 0;
      rst_check = 1;
      m_busy = 0; m_error = 0; m_err_pending = 0; m_zero_pending = 0; m_out = 0;
      q_fifo.delete(); tq_addr.delete(); tq_cyc.delete();
      return;
    end
    rst_n = 1;

    if (start_req) begin
      Start = 1;
      BaseAddr = 12'(start_base);
      Length = 12'(start_len);
      start_req = 0;
      start_cyc = cycle;
      if (start_len == 0) begin
        m_zero_pending = 1;
      end else begin
        m_busy = 1; m_base = start_base; m_len = start_len;
        m_issued = 0; m_popped = 0; m_out = 0; resp_idx = 0; m_error = 0;
      end
    end else if (m_busy && int'($urandom_range(99)) < stray_pct) begin
      Start = 1;
      BaseAddr = 12'($urandom);
      Length = 12'($urandom_range(1, 50));
    end

    STALL = int'($urandom_range(99)) < stall_pct;
    if (stall2_left > 0 && STB && m_issued == 1) begin
      STALL = 1;
      stall2_left--;
    end

    if (tq_addr.size() > 0 && tq_cyc[0] < cycle && int'($urandom_range(99)) < ack_pct) begin
      a = tq_addr.pop_front();
      void'(tq_cyc.pop_front());
      if (resp_idx == err_at) begin
        ERR = 1;
      end else begin
        ACK = 1;
        DAT = mem_data[a];
        TGD = mem_tgd[a];
      end
      resp_idx++;
    end
    OutReady = int'($urandom_range(99)) < ready_pct;

    // Events taking effect at the coming edge
    if (STB && !STALL) begin
      tq_addr.push_back(int'(ADDR));
      tq_cyc.push_back(cycle);
      acc_addr.push_back(int'(ADDR));
      acc_cyc.push_back(cycle);
      m_issued++;
      m_out++;
    end
    if (OutValid && OutReady && q_fifo.size() > 0) begin
      w = q_fifo.pop_front();
      ea = (m_base + m_popped) % AMOD;
      chk("stream_order", w, {mem_tgd[ea], mem_data[ea]});
      m_popped++;
    end
    if (ACK) begin
      q_fifo.push_back({TGD, DAT});
      m_out--;
    end
    if (ERR) begin
      m_error = 1;
      m_err_pending = 1;
      m_out = 0;
      q_fifo.delete(); tq_addr.delete(); tq_cyc.delete();
    end
  endtask

  task automatic begin_transfer(input int base, input int len);
    start_req = 1; start_base = base; start_len = len;
    acc_addr.delete(); acc_cyc.delete();
    first_stb = -1; first_valid = -1; done_cyc = -1;
    done_count = 0; t3_count = 0; cyc_seen = 0;
    step();
  endtask

  task automatic finish_transfer(input int max_cyc);
    for (int i = 0; i < max_cyc && (m_busy || m_zero_pending || m_err_pending); i++) step();
    chk("xfer_timeout", m_busy || m_zero_pending || m_err_pending, 0);
    chk("done_count", done_count, 1);
    $display("xfer base=%03h len=%0d issued=%0d delivered=%0d error=%0b cycles=%0d",
             m_base, m_len, m_issued, m_popped, m_error, done_cyc - start_cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp2[4];
    int len;
    for (int i = 0; i < AMOD; i++) begin
      mem_data[i] = 8'($urandom);
      mem_tgd[i]  = 1'($urandom);
    end
    rst_n = 0; Start = 0; BaseAddr = 0; Length = 0; STALL = 0; ACK = 0; ERR = 0;
    DAT = 0; TGD = 0; OutReady = 0;
    stall_pct = 0; ack_pct = 100; ready_pct = 100; stray_pct = 0; stall2_left = 0;
    err_at = -1; start_req = 0; rst_req = 0; m_base = 0;
    repeat (2) @(negedge clk);
    rst_check = 1;
    step();
    step();

    // Zero-wait target, consumer always ready
    begin_transfer(12'h010, 4);
    finish_transfer(50);
    chk("t1_first_stb_latency", first_stb - start_cyc, 1);
    chk("t1_first_valid_latency", first_valid - start_cyc, 3);
    chk("t1_accepts", acc_addr.size(), 4);
    for (int i = 0; i < acc_addr.size(); i++) begin
      chk("t1_addr", acc_addr[i], 12'h010 + i);
      chk("t1_back_to_back", acc_cyc[i] - acc_cyc[0], i);
    end
    chk("t1_error", Error, 0);

    // Address wrap
    begin_transfer(12'hFFE, 4);
    finish_transfer(50);
    exp2[0] = 12'hFFE; exp2[1] = 12'hFFF; exp2[2] = 12'h000; exp2[3] = 12'h001;
    chk("t2_accepts", acc_addr.size(), 4);
    for (int i = 0; i < 4 && i < acc_addr.size(); i++) chk("t2_addr", acc_addr[i], exp2[i]);

    // Second request stalled for three cycles
    stall2_left = 3;
    begin_transfer(12'h040, 4);
    finish_transfer(60);
    chk("t3_stb_cycles_on_2nd", t3_count, 4);
    chk("t3_delivered", m_popped, 4);

    // Consumer blocked: credit limits issue to the FIFO depth
    ready_pct = 0;
    begin_transfer(12'h100, 8);
    repeat (20) step();
    chk("t4_issued_while_blocked", m_issued, 4);
    ready_pct = 100;
    finish_transfer(100);
    chk("t4_issued_total", m_issued, 8);
    chk("t4_delivered", m_popped, 8);

    // ERR on the third response
    ready_pct = 0;
    err_at = 2;
    begin_transfer(12'h200, 6);
    finish_transfer(60);
    chk("t5_error", Error, 1);
    chk("t5_fifo_empty", OutValid, 0);
    err_at = -1;
    ready_pct = 100;
    begin_transfer(12'h300, 3);
    finish_transfer(60);
    chk("t5_error_cleared", Error, 0);

    // Empty transfer
    begin_transfer(12'h123, 0);
    finish_transfer(5);
    chk("t6_done_latency", done_cyc - start_cyc, 1);
    chk("t6_cyc_seen", cyc_seen, 0);

    // Reset while waiting for responses
    ack_pct = 0;
    begin_transfer(12'h050, 4);
    for (int i = 0; i < 30 && m_issued < 4; i++) step();
    chk("t7_all_issued", m_issued, 4);
    step();
    rst_req = 1;
    step();
    ack_pct = 100;
    repeat (6) step();
    chk("t7_no_done", done_count, 0);

    // Randomized transfers
    for (int t = 0; t < 40; t++) begin
      stall_pct = $urandom_range(0, 40);
      ack_pct   = $urandom_range(30, 100);
      ready_pct = $urandom_range(20, 100);
      stray_pct = 5;
      len = $urandom_range(1, 16);
      err_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      begin_transfer(int'($urandom_range(0, AMOD - 1)), len);
      finish_transfer(2000);
      if (err_at < 0) chk("rand_delivered", m_popped, len);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
